bf_weighted_combiner: RTL

Parametrised beamforming combiner. It applies a per-channel complex weight to NCH parallel complex sample streams, then sums the weighted streams through a registered adder tree of log2(NCH) levels. It replaces the fixed 4-input, unweighted, wrap-around complex adder tree with the following:
- run-time weights, double-buffered with atomic commit;
- a valid pipeline;
- rounding;
- output saturation with a sticky overflow flag.

It sits between the per-channel decimating FIR outputs and the beam output.

---
 rtl/bf_pkg.sv | 27 ++
 rtl/bf_cmul_round.sv | 58 +++++
 rtl/bf_weighted_combiner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bf_pkg.sv
// Shared widths, unity-weight helper and output saturation for the beamforming combiner.
package bf_pkg;

  localparam int DW_DEF    = 16;
  localparam int CW_DEF    = 16;
  localparam int CFRAC_DEF = 14;
  localparam int PW_DEF    = DW_DEF + CW_DEF + 1;
  localparam int RW_DEF    = PW_DEF - CFRAC_DEF;

  localparam logic [CW_DEF-1:0] UNITY_RE_DEF = CW_DEF'(1) << CFRAC_DEF;

  function automatic logic [63:0] unity_weight(input int cfrac);
    return 64'd1 << cfrac;
  endfunction

  // Clip a wide signed value into a w-bit two's complement range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/bf_cmul_round.sv
// One channel: full-precision complex multiply, then round half-up by CFRAC bits.
module bf_cmul_round #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int CFRAC = 14
) (
  input  logic                        CLK,
  input  logic                        rst,
  input  logic                        en_mul,
  input  logic                        en_rnd,
  input  logic signed [DW-1:0]        ar,
  input  logic signed [DW-1:0]        ai,
  input  logic signed [CW-1:0]        wr,
  input  logic signed [CW-1:0]        wi,
  output logic signed [DW+CW-CFRAC:0] re,
  output logic signed [DW+CW-CFRAC:0] im
);

  localparam int PW = DW + CW + 1;
  localparam int RW = PW - CFRAC;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (CFRAC - 1);

  logic signed [PW-1:0] prod_re_d, prod_re_q, prod_im_d, prod_im_q;
  logic signed [RW-1:0] rnd_re_d, rnd_re_q, rnd_im_d, rnd_im_q;

  always_comb begin
    prod_re_d = prod_re_q;
    prod_im_d = prod_im_q;
    rnd_re_d  = rnd_re_q;
    rnd_im_d  = rnd_im_q;
    if (en_mul) begin
      prod_re_d = PW'(ar) * PW'(wr) - PW'(ai) * PW'(wi);
      prod_im_d = PW'(ar) * PW'(wi) + PW'(ai) * PW'(wr);
    end
    if (en_rnd) begin
      rnd_re_d = RW'((prod_re_q + HALF) >>> CFRAC);
      rnd_im_d = RW'((prod_im_q + HALF) >>> CFRAC);
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      prod_re_q <= '0;
      prod_im_q <= '0;
      rnd_re_q  <= '0;
      rnd_im_q  <= '0;
    end else begin
      prod_re_q <= prod_re_d;
      prod_im_q <= prod_im_d;
      rnd_re_q  <= rnd_re_d;
      rnd_im_q  <= rnd_im_d;
    end
  end

  assign re = rnd_re_q;
  assign im = rnd_im_q;

endmodule

// File: rtl/bf_weighted_combiner.sv
// NCH-channel weighted complex beam combiner: double-buffered weights, registered
// adder tree, saturated output with sticky overflow flag.
module bf_weighted_combiner
  import bf_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int CFRAC = CFRAC_DEF
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NCH*DW-1:0]        in_real,
  input  logic [NCH*DW-1:0]        in_imag,
  input  logic                     ssb,
  input  logic [$clog2(NCH)-1:0]   sdi_ch,
  input  logic [CW-1:0]            sdi_re,
  input  logic [CW-1:0]            sdi_im,
  input  logic                     commit,
  input  logic                     sat_clr,
  output logic                     coe_load,
  output logic                     out_valid,
  output logic [DW-1:0]            out_real,
  output logic [DW-1:0]            out_imag,
  output logic                     sat
);

  localparam int LOG2N = $clog2(NCH);
  localparam int PW    = DW + CW + 1;
  localparam int RW    = PW - CFRAC;
  localparam int TW    = RW + LOG2N;
  localparam int L     = 4 + LOG2N;
  localparam logic [CW-1:0] UNITY = CW'(unity_weight(CFRAC));

  logic [CW-1:0] shd_re_d [NCH], shd_re_q [NCH], shd_im_d [NCH], shd_im_q [NCH];
  logic [CW-1:0] act_re_d [NCH], act_re_q [NCH], act_im_d [NCH], act_im_q [NCH];
  logic          coe_load_d, coe_load_q;

  // A write in the commit cycle is folded in before the copy (write-through).
  always_comb begin
    shd_re_d = shd_re_q;
    shd_im_d = shd_im_q;
    act_re_d = act_re_q;
    act_im_d = act_im_q;
    if (!ssb) begin
      shd_re_d[sdi_ch] = sdi_re;
      shd_im_d[sdi_ch] = sdi_im;
    end
    if (commit) begin
      act_re_d = shd_re_d;
      act_im_d = shd_im_d;
    end
    coe_load_d = commit;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCH; k++) begin
        shd_re_q[k] <= UNITY;
        shd_im_q[k] <= '0;
        act_re_q[k] <= UNITY;
        act_im_q[k] <= '0;
      end
      coe_load_q <= 1'b0;
    end else begin
      shd_re_q   <= shd_re_d;
      shd_im_q   <= shd_im_d;
      act_re_q   <= act_re_d;
      act_im_q   <= act_im_d;
      coe_load_q <= coe_load_d;
    end
  end

  // vld_q[0]=input reg, [1]=product, [2]=rounded, [2+l]=tree level l, [L-1]=output.
  logic [L-1:0]      vld_d, vld_q;
  logic [NCH*DW-1:0] in_real_d, in_real_q, in_imag_d, in_imag_q;

  always_comb begin
    vld_d     = {vld_q[L-2:0], in_valid};
    in_real_d = in_valid ? in_real : in_real_q;
    in_imag_d = in_valid ? in_imag : in_imag_q;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      vld_q     <= '0;
      in_real_q <= '0;
      in_imag_q <= '0;
    end else begin
      vld_q     <= vld_d;
      in_real_q <= in_real_d;
      in_imag_q <= in_imag_d;
    end
  end

  logic signed [TW-1:0] leaf_re [NCH], leaf_im [NCH];
  logic signed [TW-1:0] node_re [NCH-1], node_im [NCH-1];

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [RW-1:0] rnd_re, rnd_im;
    bf_cmul_round #(.DW(DW), .CW(CW), .CFRAC(CFRAC)) u_cmul (
      .CLK    (CLK),
      .rst    (rst),
      .en_mul (vld_q[0]),
      .en_rnd (vld_q[1]),
      .ar     ($signed(in_real_q[k*DW +: DW])),
      .ai     ($signed(in_imag_q[k*DW +: DW])),
      .wr     ($signed(act_re_q[k])),
      .wi     ($signed(act_im_q[k])),
      .re     (rnd_re),
      .im     (rnd_im)
    );
    assign leaf_re[k] = TW'(rnd_re);
    assign leaf_im[k] = TW'(rnd_im);
  end

  // Tree nodes are stored level by level; level l starts at NCH - (NCH >> (l-1)).
  for (genvar l = 1; l <= LOG2N; l++) begin : g_lvl
    localparam int BASE = NCH - (NCH >> (l - 1));
    for (genvar j = 0; j < (NCH >> l); j++) begin : g_node
      logic signed [TW-1:0] a_re, a_im, b_re, b_im;
      logic signed [TW-1:0] sum_re_d, sum_re_q, sum_im_d, sum_im_q;
      if (l == 1) begin : g_from_leaf
        assign a_re = leaf_re[2*j];
        assign b_re = leaf_re[2*j+1];
        assign a_im = leaf_im[2*j];
        assign b_im = leaf_im[2*j+1];
      end else begin : g_from_node
        localparam int PBASE = NCH - (NCH >> (l - 2));
        assign a_re = node_re[PBASE + 2*j];
        assign b_re = node_re[PBASE + 2*j + 1];
        assign a_im = node_im[PBASE + 2*j];
        assign b_im = node_im[PBASE + 2*j + 1];
      end
      always_comb begin
        sum_re_d = sum_re_q;
        sum_im_d = sum_im_q;
        if (vld_q[1+l]) begin
          sum_re_d = a_re + b_re;
          sum_im_d = a_im + b_im;
        end
      end
      always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
          sum_re_q <= '0;
          sum_im_q <= '0;
        end else begin
          sum_re_q <= sum_re_d;
          sum_im_q <= sum_im_d;
        end
      end
      assign node_re[BASE + j] = sum_re_q;
      assign node_im[BASE + j] = sum_im_q;
    end
  end

  logic signed [63:0] root_re_x, root_im_x, sat_re_x, sat_im_x;
  logic               clip_re, clip_im;
  logic [DW-1:0]      out_real_d, out_real_q, out_imag_d, out_imag_q;
  logic               sat_d, sat_q;

  always_comb begin
    root_re_x  = 64'(node_re[NCH-2]);
    root_im_x  = 64'(node_im[NCH-2]);
    sat_re_x   = saturate(root_re_x, DW);
    sat_im_x   = saturate(root_im_x, DW);
    clip_re    = (sat_re_x != root_re_x);
    clip_im    = (sat_im_x != root_im_x);
    out_real_d = out_real_q;
    out_imag_d = out_imag_q;
    sat_d      = sat_clr ? 1'b0 : sat_q;
    if (vld_q[L-2]) begin
      out_real_d = sat_re_x[DW-1:0];
      out_imag_d = sat_im_x[DW-1:0];
      if (clip_re || clip_im) sat_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      out_real_q <= '0;
      out_imag_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
      sat_q      <= sat_d;
    end
  end

  assign out_valid = vld_q[L-1];
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign sat       = sat_q;
  assign coe_load  = coe_load_q;

endmodule
